// File: rtl/bp_pkg.sv
// Shared branch predictor types: 2-bit counter states,
// the saturating-update function and the pred-taken flag bit.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WNT;

  // Instruction flag bit carrying the fetch prediction;
  // the decoder and jump control read the same bit.
  localparam int FLAG_PRED_TAKEN = 16;

  function automatic ctr_e ctr_next(
    input ctr_e cur,
    input logic taken
  );
    ctr_e nxt;
    nxt = cur;
    unique case (1'b1)
      (taken && cur != CTR_ST):
        nxt = ctr_e'(cur + 2'd1);
      (!taken && cur != CTR_SNT):
        nxt = ctr_e'(cur - 2'd1);
      default:
        nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One 2-bit saturating counter, async reset to weak not-taken.
// Ports: clk, reset, en (train), taken (direction), ctr (state).
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic taken,
  output ctr_e ctr
);

  ctr_e ctr_q;
  ctr_e ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (en) begin
      ctr_d = ctr_next(ctr_q, taken);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr_q <= CTR_RESET;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped 2-bit counters and a
// tagged BTB in flops, trained by execute-stage branch resolution.
// Ports: clk, reset (async, active-high), ena (advance);
//   fetch_valid/fetch_pc in -> pred_valid/pred_taken/pred_target
//   registered one cycle later;
//   upd_valid/upd_pc/upd_target/upd_taken/upd_pred_taken in ->
//   mispredict registered one cycle later.
// Option BP_STATS_EN adds stat_branches/stat_mispredicts counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_pred_taken,
`ifdef BP_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  output logic        mispredict
);

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             upd_go;
  logic             hit;
  logic             taken_now;
  logic             unused_ok;

  assign f_idx  = fetch_pc[IDX_W+1:2];
  assign f_tag  = fetch_pc[31:IDX_W+2];
  assign u_idx  = upd_pc[IDX_W+1:2];
  assign u_tag  = upd_pc[31:IDX_W+2];
  assign upd_go = ena && upd_valid;

  assign unused_ok = ^{fetch_pc[1:0], upd_pc[1:0]};

  ctr_e ctr [ENTRIES];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    bp_sat_ctr u_ctr (
      .clk   (clk),
      .reset (reset),
      .en    (upd_go && (u_idx == IDX_W'(i))),
      .taken (upd_taken),
      .ctr   (ctr[i])
    );
  end

  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][31:0]      tgt_q, tgt_d;

  logic        pred_valid_q, pred_valid_d;
  logic        pred_taken_q, pred_taken_d;
  logic [31:0] pred_target_q, pred_target_d;
  logic        mispredict_q, mispredict_d;

  // Reads use the pre-update table: a same-cycle update lands
  // at the edge and is seen by the following fetch.
  assign hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign taken_now = hit && ctr[f_idx][1];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (upd_go && upd_taken) begin
      valid_d[u_idx] = 1'b1;
      tag_d[u_idx]   = u_tag;
      tgt_d[u_idx]   = upd_target & ~32'd1;
    end
  end

  always_comb begin
    pred_valid_d  = pred_valid_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    mispredict_d  = mispredict_q;
    if (ena) begin
      mispredict_d = upd_valid && (upd_taken ^ upd_pred_taken);
      if (fetch_valid) begin
        pred_valid_d  = 1'b1;
        pred_taken_d  = taken_now;
        pred_target_d = taken_now ? tgt_q[f_idx]
                                  : fetch_pc + 32'd4;
      end else begin
        pred_valid_d = 1'b0;
        pred_taken_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q       <= '0;
      tag_q         <= '0;
      tgt_q         <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      mispredict_q  <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      tgt_q         <= tgt_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      mispredict_q  <= mispredict_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign mispredict  = mispredict_q;

`ifdef BP_STATS_EN
  logic [31:0] st_br_q, st_br_d;
  logic [31:0] st_mp_q, st_mp_d;

  always_comb begin
    st_br_d = st_br_q;
    st_mp_d = st_mp_q;
    if (upd_go) begin
      st_br_d = st_br_q + 32'd1;
      if (upd_taken ^ upd_pred_taken) begin
        st_mp_d = st_mp_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_br_q <= '0;
      st_mp_q <= '0;
    end else begin
      st_br_q <= st_br_d;
      st_mp_q <= st_mp_d;
    end
  end

  assign stat_branches    = st_br_q;
  assign stat_mispredicts = st_mp_q;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage branch predictor and the producer of the "predicted taken" flag that execute-stage jump control consumes.
- Closes the loop with execute: jump control reports the resolved outcome of each conditional branch; this block learns from it and predicts later fetches of the same PC.
- Structure: direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB), all in flops.
- Predictions are registered and aligned with the instruction leaving fetch.

Parameters:
- ENTRIES, 16, number of table entries (power of 2, at least 2)
- IDX_W, $clog2(ENTRIES), index width; index = pc[IDX_W+1:2]
- TAG_W, 30-IDX_W, tag width; tag = pc[31:IDX_W+2]

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- ena  in  1  pipeline advance; 0 freezes all state and outputs
- fetch_valid  in  1  fetch_pc holds a real fetch this cycle
- fetch_pc  in  32  PC being fetched
- pred_valid  out  1  prediction registered for the previous accepted fetch
- pred_taken  out  1  predicted taken; driven into instruction flag bit 16
- pred_target  out  32  predicted next PC; equals fetch_pc+4 when pred_taken=0
- upd_valid  in  1  execute resolved a conditional branch this cycle
- upd_pc  in  32  PC of the resolved branch
- upd_target  in  32  branch target (pc+imm)
- upd_taken  in  1  resolved outcome
- upd_pred_taken  in  1  prediction that travelled with that branch
- mispredict  out  1  registered; upd_taken != upd_pred_taken on a valid update

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - All counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0.
  - pred_valid = 0, pred_taken = 0, pred_target = 0, mispredict = 0.
  - Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Lookup, 1-cycle latency:
  - Condition: ena=1 and fetch_valid=1 at a rising edge.
  - hit = valid[idx] && tag[idx]==fetch_pc tag.
  - pred_taken <= hit && ctr[idx][1].
  - pred_target <= pred_taken ? btb_target[idx] : fetch_pc+4, with 32-bit wrap (0xFFFFFFFC+4 = 0).
  - pred_valid <= 1.
- Idle cycle: if ena=1 and fetch_valid=0, then pred_valid <= 0, pred_taken <= 0, pred_target holds.
- ena=0: every register holds, including the tables; an update presented that cycle is dropped.
- Update, on ena=1 and upd_valid=1:
  - Counter saturating: taken increments to a maximum of 3; not-taken decrements to a minimum of 0.
  - If upd_taken=1: write tag and target (upd_target with bit 0 cleared), set valid.
  - If upd_taken=0 and the entry tag mismatches: counter is still trained (aliasing allowed); BTB entry is untouched.
  - mispredict <= upd_taken ^ upd_pred_taken. mispredict <= 0 when there is no valid update.
- Simultaneous lookup and update to the same index: lookup sees pre-update state (read-before-write). The new state is visible to a fetch one cycle later.
- Upper-bit collision: different PCs with the same index but a different tag evict each other on taken updates.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on every accepted update.
  - stat_mispredicts increments when upd_taken != upd_pred_taken.
  - Both wrap at 2^32 and are cleared by reset.
- When undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package bp_pkg:
  - Counter state constants: CTR_SNT, CTR_WNT, CTR_WT, CTR_ST.
  - CTR_RESET = CTR_WNT.
  - Function for next-state saturating update.
  - Flag-bit position constant FLAG_PRED_TAKEN = 16, also used by the decoder and jump control.
- Sub-module bp_sat_ctr: one 2-bit saturating counter with enable, direction input and async reset to CTR_RESET; instantiated ENTRIES times via generate.

Test Plan:
- Reset then fetch 0x100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x104.
- Two taken updates at 0x100 with target 0x80, then fetch 0x100 -> pred_taken=1, pred_target=0x80. After one not-taken update, still taken (counter 11->10); after a second, pred_taken=0.
- Fetch 0x100 and taken update to 0x100 in the same cycle, starting from counter 01 -> that prediction is not taken; a fetch the next cycle predicts taken to the new target.
- Train 0x100 taken, then a taken update to 0x140 (same index for ENTRIES=16, different tag) -> fetch 0x100 gives pred_taken=0, fetch 0x140 gives pred_taken=1.
- ena=0 with upd_valid=1 and fetch_valid=1 -> no table change and outputs frozen. Reset pulse between clock edges -> outputs 0 immediately and previously trained PCs predict not-taken.
- With BP_STATS_EN: 5 updates, 2 of them with upd_taken != upd_pred_taken -> stat_branches=5, stat_mispredicts=2, and mispredict pulses for exactly 2 cycles.
